// File: rtl/match_ctrl.sv
// Frame-level scheduler for the volleyball physics step engine: latches controls per frame,
// triggers one step at a time, scores rallies and sequences serve/pause/match-over.
//
// state      | meaning
// IDLE       | power-up, waiting for start_btn
// WAIT_FRAME | play running, waiting for the next frame_tick to issue a step
// STEP       | step outstanding, waiting for phys_valid or timeout
// SERVE      | play frozen for serve_cnt frames after a point or match start
// PAUSED     | play halted by pause_btn
// OVER       | a player reached WIN_SCORE
module match_ctrl #(
  parameter int WIN_SCORE    = 15,
  parameter int SERVE_DELAY  = 60,
  parameter int STEP_TIMEOUT = 255,
  parameter int SCORE_W      = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic               start_btn,
  input  logic               pause_btn,
  input  logic [3:0]         p1_btn,
  input  logic [3:0]         p2_btn,
  input  logic               phys_valid,
  input  logic               phys_game_over,
  input  logic [1:0]         phys_winner,
  output logic               phys_en,
  output logic [3:0]         p1_ops,
  output logic [3:0]         p2_ops,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic               match_over,
  output logic [1:0]         match_winner,
  output logic [2:0]         state_o,
  output logic               frame_miss,
  output logic               timeout_err
);

  localparam int SRV_W  = $clog2(SERVE_DELAY + 2);
  localparam int STEP_W = $clog2(STEP_TIMEOUT + 2);
  localparam logic [SCORE_W-1:0] WIN     = SCORE_W'(WIN_SCORE);
  localparam logic [SRV_W-1:0]   SRV_LD  = SRV_W'(SERVE_DELAY);
  localparam logic [STEP_W-1:0]  STEP_TC = STEP_W'(STEP_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_FRAME = 3'd1,
    STEP       = 3'd2,
    SERVE      = 3'd3,
    PAUSED     = 3'd4,
    OVER       = 3'd5
  } state_t;

  state_t              state;
  logic [SRV_W-1:0]    serve_cnt;
  logic [STEP_W-1:0]   step_cnt;
  logic                pause_req;
  logic                p1_pt, p2_pt;
  logic [SCORE_W-1:0]  p1_nxt, p2_nxt;

  // The score guard keeps a stray rally flag from pushing a score past WIN_SCORE.
  assign p1_pt   = phys_game_over && (phys_winner == 2'd1) && (p1_score != WIN);
  assign p2_pt   = phys_game_over && (phys_winner == 2'd2) && (p2_score != WIN);
  assign p1_nxt  = p1_score + SCORE_W'(1);
  assign p2_nxt  = p2_score + SCORE_W'(1);
  assign state_o = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      serve_cnt    <= '0;
      step_cnt     <= '0;
      pause_req    <= 1'b0;
      phys_en      <= 1'b0;
      p1_ops       <= '0;
      p2_ops       <= '0;
      p1_score     <= '0;
      p2_score     <= '0;
      match_over   <= 1'b0;
      match_winner <= 2'd0;
      frame_miss   <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      phys_en    <= 1'b0;
      frame_miss <= 1'b0;
      case (state)
        IDLE: begin
          if (start_btn) begin
            p1_score  <= '0;
            p2_score  <= '0;
            serve_cnt <= SRV_LD;
            state     <= SERVE;
          end
        end
        WAIT_FRAME: begin
          if (pause_btn) begin
            state <= PAUSED;
          end else if (frame_tick) begin
            p1_ops   <= p1_btn;
            p2_ops   <= p2_btn;
            phys_en  <= 1'b1;
            step_cnt <= '0;
            state    <= STEP;
          end
        end
        STEP: begin
          step_cnt <= step_cnt + STEP_W'(1);
          if (frame_tick) frame_miss <= 1'b1;
          if (pause_btn) pause_req <= 1'b1;
          if (phys_valid) begin
            pause_req <= 1'b0;
            if (p1_pt || p2_pt) begin
              if (p1_pt) p1_score <= p1_nxt;
              else       p2_score <= p2_nxt;
              if ((p1_pt && p1_nxt == WIN) || (p2_pt && p2_nxt == WIN)) begin
                match_winner <= p1_pt ? 2'd1 : 2'd2;
                match_over   <= 1'b1;
                state        <= OVER;
              end else begin
                serve_cnt <= SRV_LD;
                p1_ops    <= '0;
                p2_ops    <= '0;
                state     <= SERVE;
              end
            end else begin
              state <= (pause_req || pause_btn) ? PAUSED : WAIT_FRAME;
            end
          end else if (step_cnt == STEP_TC) begin
            timeout_err <= 1'b1;
            pause_req   <= 1'b0;
            state       <= WAIT_FRAME;
          end
        end
        SERVE: begin
          if (serve_cnt == '0) begin
            state <= WAIT_FRAME;
          end else if (frame_tick) begin
            serve_cnt <= serve_cnt - SRV_W'(1);
            if (serve_cnt == SRV_W'(1)) state <= WAIT_FRAME;
          end
        end
        PAUSED: begin
          if (pause_btn) state <= WAIT_FRAME;
        end
        OVER: begin
          if (start_btn) begin
            p1_score     <= '0;
            p2_score     <= '0;
            match_winner <= 2'd0;
            match_over   <= 1'b0;
            serve_cnt    <= SRV_LD;
            state        <= SERVE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_match_ctrl.sv
// Scoreboard bench for match_ctrl: each expected step pushes the expected latched controls,
// and a monitor pops and compares them whenever phys_en fires.
module tb_match_ctrl;

  logic       clk, rst_n;
  logic       frame_tick, start_btn, pause_btn;
  logic [3:0] p1_btn, p2_btn;
  logic       phys_valid, phys_game_over;
  logic [1:0] phys_winner;
  logic       phys_en;
  logic [3:0] p1_ops, p2_ops;
  logic [4:0] p1_score, p2_score;
  logic       match_over;
  logic [1:0] match_winner;
  logic [2:0] state_o;
  logic       frame_miss, timeout_err;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  match_ctrl dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .start_btn(start_btn),
    .pause_btn(pause_btn), .p1_btn(p1_btn), .p2_btn(p2_btn), .phys_valid(phys_valid),
    .phys_game_over(phys_game_over), .phys_winner(phys_winner), .phys_en(phys_en),
    .p1_ops(p1_ops), .p2_ops(p2_ops), .p1_score(p1_score), .p2_score(p2_score),
    .match_over(match_over), .match_winner(match_winner), .state_o(state_o),
    .frame_miss(frame_miss), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every phys_en must correspond to an expected step with matching controls.
  always @(negedge clk) begin
    if (phys_en) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_phys_en got=1 want=0 at %0t", $time);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if ({p1_ops, p2_ops} !== e) begin
          bad++;
          $display("FAIL step_ops got=%h want=%h at %0t", {p1_ops, p2_ops}, e, $time);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", nm, got, want, $time);
    end
  endtask

  task automatic frame(input logic [3:0] a, input logic [3:0] b, input bit exp_step);
    if (exp_step) exp_q.push_back({a, b});
    @(negedge clk);
    frame_tick = 1'b1; p1_btn = a; p2_btn = b;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic serve(input int n);
    repeat (n) frame(4'b0000, 4'b0000, 1'b0);
  endtask

  // Called right after frame(): phys_valid lands 4 cycles after phys_en.
  task automatic step_done(input logic go, input logic [1:0] win);
    repeat (3) @(negedge clk);
    chk("in_step", state_o, 3'd2);
    phys_valid = 1'b1; phys_game_over = go; phys_winner = win;
    @(negedge clk);
    phys_valid = 1'b0; phys_game_over = 1'b0; phys_winner = 2'd0;
  endtask

  task automatic press_start();
    @(negedge clk); start_btn = 1'b1;
    @(negedge clk); start_btn = 1'b0;
  endtask

  task automatic press_pause();
    @(negedge clk); pause_btn = 1'b1;
    @(negedge clk); pause_btn = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; frame_tick = 0; start_btn = 0; pause_btn = 0;
    p1_btn = 0; p2_btn = 0; phys_valid = 0; phys_game_over = 0; phys_winner = 0;
    repeat (3) @(negedge clk);
    chk("rst_state", state_o, 3'd0);
    chk("rst_outs", {phys_en, p1_ops, p2_ops, p1_score, p2_score, match_over,
                     match_winner, frame_miss, timeout_err}, 0);
    rst_n = 1'b1;

    // Normal step after the opening serve delay
    press_start();
    chk("start_serve", state_o, 3'd3);
    serve(59);
    chk("serve_59", state_o, 3'd3);
    serve(1);
    chk("serve_done", state_o, 3'd1);
    frame(4'b0100, 4'b0000, 1'b1);
    step_done(1'b0, 2'd0);
    chk("normal_back", state_o, 3'd1);

    // P2 scores; serve freeze; re-serve step does not recount
    frame(4'b0000, 4'b0001, 1'b1);
    step_done(1'b1, 2'd2);
    chk("p2_score", p2_score, 1);
    chk("p1_score0", p1_score, 0);
    chk("point_serve", state_o, 3'd3);
    chk("ops_cleared", {p1_ops, p2_ops}, 0);
    serve(30);
    press_pause();
    chk("pause_ign_serve", state_o, 3'd3);
    serve(30);
    chk("serve2_done", state_o, 3'd1);
    frame(4'b1000, 4'b0010, 1'b1);
    step_done(1'b0, 2'd2);
    chk("no_recount", p2_score, 1);
    chk("reserve_back", state_o, 3'd1);

    // phys_valid outside STEP is ignored
    @(negedge clk); phys_valid = 1; phys_game_over = 1; phys_winner = 2'd1;
    @(negedge clk); phys_valid = 0; phys_game_over = 0; phys_winner = 2'd0;
    chk("stray_valid", p1_score, 0);

    // P1 plays up to the winning point
    for (int i = 1; i <= 15; i++) begin
      frame(4'b0001, 4'b0010, 1'b1);
      step_done(1'b1, 2'd1);
      if (i < 15) begin
        chk("p1_climb_state", state_o, 3'd3);
        serve(60);
      end
    end
    chk("p1_win_score", p1_score, 15);
    chk("p2_kept", p2_score, 1);
    chk("over_flag", match_over, 1);
    chk("over_winner", match_winner, 2'd1);
    chk("over_state", state_o, 3'd5);
    press_start();
    chk("restart_scores", {p1_score, p2_score}, 0);
    chk("restart_flags", {match_over, match_winner}, 0);
    chk("restart_state", state_o, 3'd3);
    serve(60);

    // Timeout: phys_valid withheld
    frame(4'b0010, 4'b0001, 1'b1);
    repeat (254) @(negedge clk);
    chk("pre_timeout", timeout_err, 0);
    chk("pre_timeout_st", state_o, 3'd2);
    @(negedge clk);
    chk("timeout_err", timeout_err, 1);
    chk("timeout_state", state_o, 3'd1);
    chk("timeout_scores", {p1_score, p2_score}, 0);
    frame(4'b0101, 4'b1010, 1'b1);
    step_done(1'b0, 2'd0);
    chk("after_timeout", state_o, 3'd1);

    // Overlap: frame_tick in STEP and a pending pause
    frame(4'b0011, 4'b1100, 1'b1);
    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
    chk("frame_miss", frame_miss, 1);
    @(negedge clk);
    chk("frame_miss_1cyc", frame_miss, 0);
    pause_btn = 1'b1;
    @(negedge clk); pause_btn = 1'b0; phys_valid = 1'b1;
    @(negedge clk); phys_valid = 1'b0;
    chk("pause_pending", state_o, 3'd4);
    serve(3);
    chk("paused_hold", state_o, 3'd4);
    press_pause();
    chk("unpause", state_o, 3'd1);
    @(negedge clk); frame_tick = 1'b1; pause_btn = 1'b1;
    @(negedge clk); frame_tick = 1'b0; pause_btn = 1'b0;
    chk("pause_wins", state_o, 3'd4);
    press_pause();

    // Asynchronous reset mid-step
    frame(4'b1010, 4'b0101, 1'b1);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_state", state_o, 3'd0);
    chk("arst_outs", {phys_en, p1_ops, p2_ops, p1_score, p2_score, match_over,
                      match_winner, frame_miss, timeout_err}, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
